mult_div_unit: RTL and testbench

Sequential 32-bit multiply/divide unit for the multicycle datapath, sitting directly downstream of the control unit. The control unit issues a one-cycle `start` with an operation code and two register operands. It then waits on `busy`/`done` before reading the HI/LO result registers, which it uses for MFHI/MFLO. Multiply is radix-2 shift-add; divide is restoring; both use magnitude arithmetic with a final sign-fix cycle.

---
 rtl/mult_div_unit.sv | 190 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Sequential radix-2 multiply / restoring divide unit with HI/LO results.
// Divider datapath is present only when MULTDIV_DIVIDE_EN is defined.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;

  logic               is_signed;
  logic               bypass;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] prod;

`ifdef MULTDIV_DIVIDE_EN
  logic               is_div_q, is_div_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH:0]     shifted, diff;
  logic [WIDTH-1:0]   quo, rmd;
`endif

  always_comb begin
    is_signed = ~op[0];
    a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
`ifdef MULTDIV_DIVIDE_EN
    bypass = op[1] && (b == '0);
`else
    bypass = op[1];
`endif
    msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
         + (acc_q[0] ? {1'b0, mcand_q} : '0);
    prod = neg_q ? -acc_q : acc_q;
`ifdef MULTDIV_DIVIDE_EN
    shifted = {rem_q, acc_q[WIDTH-1]};
    diff    = shifted - {1'b0, mcand_q};
    quo = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rmd = neg_rem_q ? -rem_q : rem_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MULTDIV_DIVIDE_EN
    is_div_d   = is_div_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    rem_d      = rem_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (bypass) begin
            done_d = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            mcand_d = a_mag;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
`ifdef MULTDIV_DIVIDE_EN
            // divide keeps divisor in mcand, dividend/quotient in acc low
            if (op[1]) begin
              mcand_d = b_mag;
              acc_d   = {{WIDTH{1'b0}}, a_mag};
            end
`endif
          end
`ifdef MULTDIV_DIVIDE_EN
          div_zero_d = bypass;
          is_div_d   = op[1];
          neg_rem_d  = is_signed & a[WIDTH-1];
          rem_d      = '0;
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
        acc_d = {msum, acc_q[WIDTH-1:1]};
`ifdef MULTDIV_DIVIDE_EN
        if (is_div_q) begin
          rem_d = diff[WIDTH] ? shifted[WIDTH-1:0]
                              : diff[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH],
                   acc_q[WIDTH-2:0], ~diff[WIDTH]};
        end
`endif
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        hi_d    = prod[2*WIDTH-1:WIDTH];
        lo_d    = prod[WIDTH-1:0];
`ifdef MULTDIV_DIVIDE_EN
        if (is_div_q) begin
          hi_d = rmd;
          lo_d = quo;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

`ifdef MULTDIV_DIVIDE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      is_div_q   <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      rem_q      <= '0;
    end else begin
      is_div_q   <= is_div_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      rem_q      <= rem_d;
    end
  end

  assign div_zero = div_zero_q;
`else
  assign div_zero = 1'b0;
`endif

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit; divide vectors run only when
// MULTDIV_DIVIDE_EN is defined, otherwise the disabled-divide path is checked.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_chk = 0;
  int n_pass = 0;
  int done_seen = 0;
  logic [2*W:0] sb[$];
  logic [2*W:0] exp_v;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [95:0] act,
                     input logic [95:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // monitor: every done pulse must match the oldest expected result
  always @(negedge clock) begin
    if (!reset && done) begin
      done_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 96'(done), 96'(0));
      end else begin
        exp_v = sb.pop_front();
        chk("result", 96'({busy, hi, lo, div_zero}),
            96'({1'b0, exp_v}));
      end
    end
  end

  task automatic launch(input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit push,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic ed);
    start = 1'b1; op = o; a = x; b = y;
    if (push) sb.push_back({eh, el, ed});
    @(negedge clock);
    start = 1'b0; op = ~o; a = ~x; b = ~y;
  endtask

  task automatic wait_done(input string name, input int exp_lat,
                           input int exp_busy);
    int lat = 0;
    int nb = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(negedge clock);
      lat++;
      if (busy) nb++;
    end
    if (!done) chk({name, "_timeout"}, 96'(done), 96'(1));
    if (exp_lat >= 0) chk({name, "_latency"}, 96'(lat), 96'(exp_lat));
    if (exp_busy >= 0) chk({name, "_busy_cycles"}, 96'(nb), 96'(exp_busy));
  endtask

  task automatic run_op(input string name, input logic [1:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic ed, input int lat, input int nb);
    @(negedge clock);
    launch(o, x, y, 1'b1, eh, el, ed);
    wait_done(name, lat, nb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("reset_state", 96'({busy, done, hi, lo, div_zero}), 96'(0));
    reset = 1'b0;
    @(negedge clock);
    chk("idle_after_reset", 96'({busy, done}), 96'(0));

    run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd5,
           32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33, 33);
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 33);
    run_op("mult_m1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'h00000000, 32'h00000001, 1'b0, 33, 33);
`ifdef MULTDIV_DIVIDE_EN
    run_op("div_neg_dvd", 2'b10, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 33);
    run_op("div_neg_dvs", 2'b10, 32'd7, 32'hFFFFFFFE,
           32'h00000001, 32'hFFFFFFFD, 1'b0, 33, 33);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF,
           32'h00000000, 32'h80000000, 1'b0, 33, 33);
    run_op("divu_big", 2'b11, 32'hFFFFFFFF, 32'h10,
           32'h0000000F, 32'h0FFFFFFF, 1'b0, 33, 33);
    run_op("divu_small", 2'b11, 32'd100, 32'd7,
           32'd2, 32'd14, 1'b0, 33, 33);
`endif
    run_op("preload", 2'b01, 32'h00010000, 32'h12345678,
           32'h00001234, 32'h56780000, 1'b0, 33, 33);
`ifdef MULTDIV_DIVIDE_EN
    run_op("divu_zero", 2'b11, 32'd5, 32'd0,
           32'h00001234, 32'h56780000, 1'b1, 0, 0);
`else
    run_op("div_off", 2'b10, 32'd100, 32'd7,
           32'h00001234, 32'h56780000, 1'b0, 0, 0);
    run_op("divu_off", 2'b11, 32'hFFFFFFFF, 32'd0,
           32'h00001234, 32'h56780000, 1'b0, 0, 0);
`endif
    @(negedge clock);
    launch(2'b00, 32'd6, 32'hFFFFFFF9, 1'b1,
           32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
    chk("dz_clear_at_accept", 96'({busy, div_zero}), 96'(2'b10));
    wait_done("mult_after_dz", 33, 33);

    @(negedge clock);
    launch(2'b01, 32'h00010000, 32'd3, 1'b1,
           32'h0, 32'h00030000, 1'b0);
    repeat (9) @(negedge clock);
    start = 1'b1; op = 2'b00; a = 32'hFFFFFFFF; b = 32'd7;
    @(negedge clock);
    start = 1'b0;
    wait_done("ignore_start", -1, -1);

    @(negedge clock);
    launch(2'b01, 32'h00012345, 32'h100, 1'b1,
           32'h0, 32'h01234500, 1'b0);
    wait_done("b2b_first", 33, 33);
    launch(2'b00, 32'h80000000, 32'd2, 1'b1,
           32'hFFFFFFFF, 32'h00000000, 1'b0);
    chk("b2b_done_drop", 96'({done, busy}), 96'(2'b01));
    chk("b2b_hold", 96'({hi, lo}), 96'({32'h0, 32'h01234500}));
    wait_done("b2b_second", 33, 33);

    @(negedge clock);
    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '0, '0, 1'b0);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    done_seen = 0;
    #1;
    chk("reset_mid", 96'({busy, done, hi, lo, div_zero}), 96'(0));
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("no_done_after_reset", 96'(done_seen), 96'(0));

    run_op("post_reset", 2'b01, 32'd7, 32'd6,
           32'd0, 32'd42, 1'b0, 33, 33);

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", 96'(sb.size()), 96'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
